rgb_pwm_sequencer: RTL and testbench

//  Multi-channel PWM generator driving the SB_RGBA_DRV RGBnPWM inputs from the SB_HFOSC clock.

---
 rtl/rgb_pwm_pkg.sv | 19 +
 rtl/rgb_pwm_chan.sv | 87 ++++++++
 rtl/rgb_pwm_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared mode encoding and constants for the RGB PWM sequencer
//
// Contents:
//   mode_t    global sequencer mode (OFF, STATIC, BREATHE, CYCLE), 2-bit encoding
//             matching the cfg_mode input
//   CH_IDX_W  width of the channel index (cfg_ch, seq_idx); covers up to 8 channels

package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_CYCLE   = 2'd3
    } mode_t;

    localparam int CH_IDX_W = 3;

endpackage

// File: rtl/rgb_pwm_chan.sv
// rtl/rgb_pwm_chan.sv - one PWM channel: effective-duty register, optional gamma, compare flop
//
// Optional feature: RGB_GAMMA_EN (squares the duty before compare, adds one pipeline stage)
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous reset, active-high
//   load    in   period boundary strobe; eff is recomputed only here
//   mode    in   mode that takes effect for the coming period
//   target  in   registered target duty of this channel
//   level   in   breathe brightness for the coming period
//   sel     in   this channel is the active one in CYCLE mode for the coming period
//   cnt     in   shared PWM period counter
//   pwm     out  registered PWM output

module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  mode_t            mode,
    input  logic [PWM_W-1:0] target,
    input  logic [PWM_W-1:0] level,
    input  logic             sel,
    input  logic [PWM_W-1:0] cnt,
    output logic             pwm
);

    logic [2*PWM_W-1:0] breathe_prod;
    logic [PWM_W-1:0]   eff_next;
    logic [PWM_W-1:0]   eff;

    // Full-width product so the scaled duty is a plain truncating shift.
    assign breathe_prod = {{PWM_W{1'b0}}, target} * {{PWM_W{1'b0}}, level};

    always_comb begin
        eff_next = '0;
        case (mode)
            MODE_OFF:     eff_next = '0;
            MODE_STATIC:  eff_next = target;
            MODE_BREATHE: eff_next = PWM_W'(breathe_prod >> PWM_W);
            MODE_CYCLE:   eff_next = sel ? target : '0;
            default:      eff_next = '0;
        endcase
    end

    // Duty only changes at the period boundary so a period is never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eff <= '0;
        end else if (load) begin
            eff <= eff_next;
        end
    end

`ifdef RGB_GAMMA_EN
    logic [2*PWM_W-1:0] gamma_prod;
    logic [PWM_W-1:0]   gamma_duty;
    logic               hit_q;

    assign gamma_prod = {{PWM_W{1'b0}}, eff} * {{PWM_W{1'b0}}, eff};
    assign gamma_duty = PWM_W'(gamma_prod >> PWM_W);

    // The extra flop breaks the multiply-compare path; pwm lags cnt by 2 clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= 1'b0;
            pwm   <= 1'b0;
        end else begin
            hit_q <= (cnt < gamma_duty);
            pwm   <= hit_q;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < eff);
        end
    end
`endif

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// rtl/rgb_pwm_sequencer.sv - multi-channel PWM sequencer with off/static/breathe/cycle modes
//
// Optional feature: RGB_GAMMA_EN (per-channel gamma stage inside rgb_pwm_chan)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   cfg_we      in   write strobe for a channel target duty
//   cfg_ch      in   channel index for cfg_we; indices >= NUM_CH are ignored
//   cfg_duty    in   target duty value
//   cfg_mode    in   global mode request, taken at each period boundary
//   pwm         out  PWM outputs, one per channel
//   period_end  out  1-cycle pulse on the clk where the period counter wraps to 0

module rgb_pwm_sequencer
    import rgb_pwm_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int PWM_W        = 8,
    parameter int PRESC_DIV    = 187,
    parameter int HOLD_PERIODS = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_ch,
    input  logic [PWM_W-1:0]    cfg_duty,
    input  logic [1:0]          cfg_mode,
    output logic [NUM_CH-1:0]   pwm,
    output logic                period_end
);

    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int HOLD_W  = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [PWM_W-1:0]   CNT_MAX  = '1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_PERIODS - 1);
    localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(NUM_CH - 1);

    logic [PRESC_W-1:0]  presc;
    logic                tick;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                wrap;

    logic [PWM_W-1:0]    target [NUM_CH];

    mode_t               mode_act;
    mode_t               mode_new;
    logic [PWM_W-1:0]    level;
    logic [PWM_W-1:0]    level_next;
    logic                dir_up;
    logic                dir_up_next;
    logic [CH_IDX_W-1:0] seq_idx;
    logic [CH_IDX_W-1:0] seq_next;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   hold_next;

    assign tick       = (presc == PRESC_MAX);
    assign wrap       = tick && (pwm_cnt == CNT_MAX);
    assign period_end = wrap;
    assign mode_new   = mode_t'(cfg_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
        end
    end

    // Matching against each in-range index makes out-of-range cfg_ch a no-op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                target[n] <= '0;
            end
        end else if (cfg_we) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (cfg_ch == CH_IDX_W'(n)) begin
                    target[n] <= cfg_duty;
                end
            end
        end
    end

    // Breathe level for the coming period: 0,1..max,max-1..1,0,1..
    always_comb begin
        level_next  = level;
        dir_up_next = dir_up;
        if (mode_new == MODE_BREATHE) begin
            if (mode_act != MODE_BREATHE) begin
                level_next  = '0;
                dir_up_next = 1'b1;
            end else if (dir_up) begin
                if (level == CNT_MAX) begin
                    level_next  = level - PWM_W'(1);
                    dir_up_next = 1'b0;
                end else begin
                    level_next = level + PWM_W'(1);
                end
            end else begin
                if (level == '0) begin
                    level_next  = level + PWM_W'(1);
                    dir_up_next = 1'b1;
                end else begin
                    level_next = level - PWM_W'(1);
                end
            end
        end
    end

    // Round-robin channel for the coming period; the entry period counts as hold 0.
    always_comb begin
        seq_next  = seq_idx;
        hold_next = hold;
        if (mode_new == MODE_CYCLE) begin
            if (mode_act != MODE_CYCLE) begin
                seq_next  = '0;
                hold_next = '0;
            end else if (hold == HOLD_MAX) begin
                hold_next = '0;
                seq_next  = (seq_idx == LAST_CH) ? '0 : seq_idx + CH_IDX_W'(1);
            end else begin
                hold_next = hold + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_act <= MODE_OFF;
            level    <= '0;
            dir_up   <= 1'b1;
            seq_idx  <= '0;
            hold     <= '0;
        end else if (wrap) begin
            mode_act <= mode_new;
            level    <= level_next;
            dir_up   <= dir_up_next;
            seq_idx  <= seq_next;
            hold     <= hold_next;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        rgb_pwm_chan #(
            .PWM_W (PWM_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .load   (wrap),
            .mode   (mode_new),
            .target (target[n]),
            .level  (level_next),
            .sel    (seq_next == CH_IDX_W'(n)),
            .cnt    (pwm_cnt),
            .pwm    (pwm[n])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb/tb_rgb_pwm_sequencer.sv - self-checking bench for rgb_pwm_sequencer

module tb_rgb_pwm_sequencer;

    localparam logic [1:0] M_OFF     = 2'd0;
    localparam logic [1:0] M_STATIC  = 2'd1;
    localparam logic [1:0] M_BREATHE = 2'd2;
    localparam logic [1:0] M_CYCLE   = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_duty;
    logic [1:0] cfg_mode;
    logic [2:0] pwm;
    logic       period_end;

    logic       s_we;
    logic [2:0] s_ch;
    logic [3:0] s_duty;
    logic [1:0] s_mode;
    logic [0:0] s_pwm;
    logic       s_pe;

    int errors = 0;
    int checks = 0;
    int hi [3];
    int pe_seen;

    typedef struct {
        logic [1:0] mode;
        int t0, t1, t2;
        int e0, e1, e2;
    } vec_t;

    vec_t vecs [5];

    rgb_pwm_sequencer #(
        .NUM_CH(3), .PWM_W(8), .PRESC_DIV(1), .HOLD_PERIODS(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_duty(cfg_duty),
        .cfg_mode(cfg_mode), .pwm(pwm), .period_end(period_end)
    );

    // Narrow instance so a full breathe cycle (30 periods of 16 clk) fits the run.
    rgb_pwm_sequencer #(
        .NUM_CH(1), .PWM_W(4), .PRESC_DIV(1), .HOLD_PERIODS(1)
    ) dut_small (
        .clk(clk), .rst(rst), .cfg_we(s_we), .cfg_ch(s_ch), .cfg_duty(s_duty),
        .cfg_mode(s_mode), .pwm(s_pwm), .period_end(s_pe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int shape(input int x, input int w);
`ifdef RGB_GAMMA_EN
        return (x * x) >> w;
`else
        return x + 0 * w;
`endif
    endfunction

    task automatic wr(input logic [2:0] ch, input logic [7:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_duty = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_pe();
        int n = 0;
        while (period_end !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (period_end !== 1'b1) check("period_end_timeout", 0, 1);
    endtask

    // Counts high clks per channel over the period that starts at the next boundary.
    task automatic measure(input int wr_at, input logic [2:0] wch, input logic [7:0] wduty);
        wait_pe();
        for (int c = 0; c < 3; c++) hi[c] = 0;
        pe_seen = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            @(negedge clk);
            cfg_we = 1'b0;
            for (int c = 0; c < 3; c++) if (pwm[c]) hi[c]++;
            if (period_end) pe_seen++;
            if (k == wr_at) begin
                cfg_we = 1'b1; cfg_ch = wch; cfg_duty = wduty;
            end
        end
    endtask

    task automatic s_measure(output int h);
        int n = 0;
        while (s_pe !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (s_pe !== 1'b1) check("small_period_end_timeout", 0, 1);
        h = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_pwm[0]) h++;
        end
    endtask

    initial begin
        int h;
        int lvl;
        int m;
        int act;

        rst = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_duty = '0; cfg_mode = M_OFF;
        s_we = 1'b0; s_ch = '0; s_duty = '0; s_mode = M_OFF;

        vecs[0] = '{M_STATIC, 0, 128, 255, 0, 128, 255};
        vecs[1] = '{M_STATIC, 1, 254, 17, 1, 254, 17};
        vecs[2] = '{M_STATIC, 255, 0, 64, 255, 0, 64};
        vecs[3] = '{M_OFF, 200, 200, 200, 0, 0, 0};
        vecs[4] = '{M_STATIC, 16, 32, 100, 16, 32, 100};

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_period_end", int'(period_end), 0);
        check("reset_small_pwm", int'(s_pwm), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven static/off vectors
        for (int i = 0; i < 5; i++) begin
            cfg_mode = vecs[i].mode;
            wr(3'd0, 8'(vecs[i].t0));
            wr(3'd1, 8'(vecs[i].t1));
            wr(3'd2, 8'(vecs[i].t2));
            measure(-1, 3'd0, 8'd0);
            check($sformatf("vec%0d_ch0", i), hi[0], shape(vecs[i].e0, 8));
            check($sformatf("vec%0d_ch1", i), hi[1], shape(vecs[i].e1, 8));
            check($sformatf("vec%0d_ch2", i), hi[2], shape(vecs[i].e2, 8));
            check($sformatf("vec%0d_period_end_pulses", i), pe_seen, 1);
        end

        // Duty updates only at boundaries
        cfg_mode = M_STATIC;
        wr(3'd0, 8'd0); wr(3'd1, 8'd128); wr(3'd2, 8'd255);
        measure(-1, 3'd0, 8'd0);
        check("upd_base", hi[1], shape(128, 8));
        measure(100, 3'd1, 8'd64);
        check("upd_midwrite_same_period", hi[1], shape(128, 8));
        measure(255, 3'd1, 8'd32);
        check("upd_next_period", hi[1], shape(64, 8));
        measure(-1, 3'd0, 8'd0);
        check("upd_boundary_write_delayed", hi[1], shape(64, 8));
        measure(-1, 3'd0, 8'd0);
        check("upd_boundary_write_applied", hi[1], shape(32, 8));

        // Breathe start on the 8-bit instance
        wr(3'd0, 8'd255); wr(3'd1, 8'd0); wr(3'd2, 8'd0);
        cfg_mode = M_BREATHE;
        for (int i = 0; i < 5; i++) begin
            measure(-1, 3'd0, 8'd0);
            check($sformatf("breathe_w8_p%0d", i), hi[0], shape((255 * i) >> 8, 8));
        end

        // Full breathe cycle with reversal at max and at 0 on the 4-bit instance
        s_we = 1'b1; s_ch = 3'd0; s_duty = 4'd15;
        @(negedge clk);
        s_we = 1'b0;
        s_mode = M_BREATHE;
        for (int i = 0; i < 34; i++) begin
            s_measure(h);
            m = i % 30;
            lvl = (m <= 15) ? m : 30 - m;
            check($sformatf("breathe_w4_p%0d", i), h, shape((15 * lvl) >> 4, 4));
        end

        // Cycle mode, with an out-of-range write that must not land anywhere
        wr(3'd0, 8'd200); wr(3'd1, 8'd200); wr(3'd2, 8'd200);
        wr(3'd5, 8'd10);
        cfg_mode = M_CYCLE;
        for (int i = 0; i < 8; i++) begin
            measure(-1, 3'd0, 8'd0);
            for (int c = 0; c < 3; c++)
                check($sformatf("cycle_p%0d_ch%0d", i, c), hi[c],
                      (c == (i / 2) % 3) ? shape(200, 8) : 0);
        end

        // Async reset mid-period while channel 1 is lit
        repeat (20) @(negedge clk);
        check("pre_reset_active", int'(pwm), 2);
        rst = 1'b1;
        #1;
        check("async_reset_pwm", int'(pwm), 0);
        repeat (3) @(negedge clk);
        check("in_reset_period_end", int'(period_end), 0);
        rst = 1'b0;
        wr(3'd0, 8'd200); wr(3'd1, 8'd200); wr(3'd2, 8'd200);
        act = 0;
        for (int k = 0; k < 240; k++) begin
            @(negedge clk);
            if (pwm != 3'b000) act++;
        end
        check("post_reset_off_mode", act, 0);
        for (int i = 0; i < 3; i++) begin
            measure(-1, 3'd0, 8'd0);
            for (int c = 0; c < 3; c++)
                check($sformatf("post_reset_cycle_p%0d_ch%0d", i, c), hi[c],
                      (c == i / 2) ? shape(200, 8) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
